// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and default frame timing so the
// receive and transmit paths agree on bit time and payload width.
package uart_pkg;

    localparam int DEFAULT_DELAY_COUNTS = 11;
    localparam int DEFAULT_DATA_WIDTH   = 8;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = IDLE,
        ST_START  = START,
        ST_DATA   = DATA,
        ST_PARITY = PARITY,
        ST_STOP   = STOP
    } tx_state_t;

endpackage

// File: rtl/tx_bit_tick.sv
// Bit-rate divider: counts 0..delay_counts-1 while enabled and flags the last
// count of every bit period; held at zero whenever disabled.
module tx_bit_tick #(
    parameter int delay_counts = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CW = (delay_counts > 1) ? $clog2(delay_counts) : 1;
    localparam logic [CW-1:0] LAST = CW'(delay_counts - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = enable && (r_count == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter with start/busy/done handshake; all outputs registered.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx
    import uart_pkg::*;
#(
    parameter int delay_counts = DEFAULT_DELAY_COUNTS,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

    tx_state_t             r_state;
    tx_state_t             w_state_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [IW-1:0]         r_idx;
    logic [IW-1:0]         w_idx_next;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_tx_next;
    logic                  w_tick;
`ifdef UART_TX_PARITY_EN
    logic                  r_parity;
`endif

    tx_bit_tick #(
        .delay_counts(delay_counts)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .enable(r_state != ST_IDLE),
        .tick  (w_tick)
    );

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_idx_next   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (tx_start) begin
                    w_state_next = ST_START;
                    w_shift_next = tx_data;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_next = ST_DATA;
                    w_idx_next   = '0;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_next = r_shift >> 1;
                    w_idx_next   = r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The line level is derived from the state being entered so tx changes
    // on the same edge as the state, with no input-to-output path.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_tx_next = r_parity;
`endif
            default:   w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_idx   <= w_idx_next;
            r_tx    <= w_tx_next;
            r_busy  <= (w_state_next != ST_IDLE);
            r_done  <= (r_state == ST_STOP) && w_tick;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if ((r_state == ST_IDLE) && tx_start) begin
            r_parity <= ^tx_data;
        end
    end
`endif

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at delay_counts=4: per-cycle reference model
// plus table-driven frame captures and hand-written corner sequences.
module tb_uart_tx;

    localparam int D = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int checks = 0;
    int errors = 0;

    uart_tx #(.delay_counts(D), .DATA_WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of expected {tx, busy, done} values, one per
    // cycle, filled with a whole frame when a request is accepted while idle.
    typedef struct packed {logic tx; logic busy; logic done;} exp_t;
    exp_t exp_q[$];
    exp_t exp_cur = '{tx: 1'b1, busy: 1'b0, done: 1'b0};
    logic chk_en = 1'b0;

    task automatic push_frame(input logic [7:0] d);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^d);
`endif
        bits.push_back(1'b1);
        foreach (bits[b])
            for (int k = 0; k < D; k++)
                exp_q.push_back('{tx: bits[b], busy: 1'b1, done: 1'b0});
        exp_q.push_back('{tx: 1'b1, busy: 1'b0, done: 1'b1});
    endtask

    initial forever begin
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_cur = '{tx: 1'b1, busy: 1'b0, done: 1'b0};
        end else begin
            if (exp_q.size() == 0 && tx_start) push_frame(tx_data);
            if (exp_q.size() > 0) exp_cur = exp_q.pop_front();
            else exp_cur = '{tx: 1'b1, busy: 1'b0, done: 1'b0};
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            checks++;
            if ({tx, tx_busy, tx_done} !== exp_cur) begin
                errors++;
                $display("FAIL model t=%0t act tx/busy/done=%b%b%b exp=%b%b%b",
                         $time, tx, tx_busy, tx_done, exp_cur.tx, exp_cur.busy, exp_cur.done);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", (exp_q.size() == 0) ? 1 : 0, 1);
    endtask

    // Sends one frame and samples tx mid-bit; inject>=0 pulses an 0xFF request
    // at that cycle of the frame.
    task automatic send_frame(input logic [7:0] d, input int inject,
                              output logic [10:0] cap, output int busy_cnt);
        wait_idle();
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = d;
        cap      = '0;
        busy_cnt = 0;
        for (int c = 0; c < NB * D; c++) begin
            @(negedge clk);
            if (c == 0) tx_start = 1'b0;
            if (c == inject) begin
                tx_start = 1'b1;
                tx_data  = 8'hFF;
            end
            if (c == inject + 1) tx_start = 1'b0;
            if (tx_busy) busy_cnt++;
            if (c % D == D / 2) cap[c / D] = tx;
        end
        @(negedge clk);
        chk("done_at_frame_end", {31'd0, tx_done}, 1);
        chk("busy_low_at_end", {31'd0, tx_busy}, 0);
        $display("frame data=%02h cap=%03h busy_cycles=%0d", d, cap, busy_cnt);
    endtask

    typedef struct {logic [7:0] data; logic [9:0] frame; logic par;} vec_t;
    vec_t tbl[8];

    function automatic logic [10:0] exp_cap(input vec_t v);
`ifdef UART_TX_PARITY_EN
        return {1'b1, v.par, v.frame[8:0]};
`else
        return {1'b0, v.frame};
`endif
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [10:0] cap;
        int          bc;
        int          t1, t2, n, dn;

        tbl[0] = '{data: 8'h55, frame: 10'b1_0101_0101_0, par: 1'b0};
        tbl[1] = '{data: 8'hA3, frame: 10'b1_1010_0011_0, par: 1'b0};
        tbl[2] = '{data: 8'h07, frame: 10'b1_0000_0111_0, par: 1'b1};
        tbl[3] = '{data: 8'h00, frame: 10'b1_0000_0000_0, par: 1'b0};
        tbl[4] = '{data: 8'hFF, frame: 10'b1_1111_1111_0, par: 1'b0};
        tbl[5] = '{data: 8'h80, frame: 10'b1_1000_0000_0, par: 1'b1};
        tbl[6] = '{data: 8'h3C, frame: 10'b1_0011_1100_0, par: 1'b0};
        tbl[7] = '{data: 8'h0F, frame: 10'b1_0000_1111_0, par: 1'b0};

        // Reset and idle
        rst = 1'b1;
        tx_start = 1'b0;
        tx_data = 8'h00;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_tx", {31'd0, tx}, 1);
        chk("reset_busy", {31'd0, tx_busy}, 0);
        chk("reset_done", {31'd0, tx_done}, 0);
        repeat (100) @(negedge clk);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].data, -1, cap, bc);
            chk($sformatf("frame_%02h", tbl[i].data), {21'd0, cap}, {21'd0, exp_cap(tbl[i])});
            chk($sformatf("busy_len_%02h", tbl[i].data), bc, NB * D);
        end

        // Ignored request mid-frame
        send_frame(8'hA3, 12, cap, bc);
        chk("ignored_req_frame", {21'd0, cap}, {21'd0, exp_cap(tbl[1])});
        dn = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (tx_done) dn++;
            if (tx_busy) dn += 100;
        end
        chk("ignored_req_no_second", dn, 0);

        // Back-to-back with tx_start held high
        wait_idle();
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = 8'h01;
        n = 0;
        t1 = -1;
        while (t1 < 0 && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) tx_data = 8'h80;
            if (tx_done) t1 = n;
        end
        chk("b2b_first_done", t1, NB * D + 1);
        chk("b2b_gap_high", {31'd0, tx}, 1);
        @(negedge clk);
        n++;
        tx_start = 1'b0;
        chk("b2b_second_start", {31'd0, tx}, 0);
        t2 = -1;
        while (t2 < 0 && n < 400) begin
            @(negedge clk);
            n++;
            if (tx_done) t2 = n;
        end
        chk("b2b_done_spacing", t2 - t1, NB * D + 1);
        $display("back_to_back done1=%0d done2=%0d", t1, t2);

        // Reset mid-frame, with a simultaneous request that must be dropped
        wait_idle();
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = 8'h0F;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (4 * D) @(negedge clk);
        rst = 1'b1;
        tx_start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tx_start = 1'b0;
        chk("midreset_tx", {31'd0, tx}, 1);
        chk("midreset_busy", {31'd0, tx_busy}, 0);
        dn = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (tx_done || tx_busy) dn++;
        end
        chk("midreset_no_done", dn, 0);
        send_frame(8'h3C, -1, cap, bc);
        chk("after_reset_frame", {21'd0, cap}, {21'd0, exp_cap(tbl[6])});

        // Randomised traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 399) == 0);
            tx_start = ($urandom_range(0, 3) == 0);
            tx_data  = 8'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        tx_start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
